// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bundles the write, read and issue signals of the multi-port register file.
// Packing: port k occupies [k*ADDR_W +: ADDR_W] of waddr/raddr and
// [k*DATA_W +: DATA_W] of wdata/rdata.
//   master : pipeline side (drives we/waddr/wdata/re/raddr/iss_*)
//   slave  : register file (drives rdata/rbusy)
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_RD-1:0]        rbusy;

    modport master (
        output we, waddr, wdata, re, raddr, iss_valid, iss_addr,
        input  rdata, rbusy
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, iss_valid, iss_addr,
        output rdata, rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file with write-first bypass and an optional
// per-register busy scoreboard.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset; clears array and busy bits and
//            forces rdata/rbusy to 0 while low
//   bus    : regfile_mp_if.slave (write ports, read ports, issue, rbusy)
// Build option: define REGFILE_SCOREBOARD_EN to include the busy scoreboard;
// otherwise rbusy is tied to 0 and iss_valid/iss_addr are ignored.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          clk_i,
    input logic          rst_ni,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ---------------- register array ----------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Ascending port order: the highest-index port to an address wins.
    always_comb begin
        logic [ADDR_W-1:0] wa;
        wa     = '0;
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            wa = bus.waddr[k*ADDR_W +: ADDR_W];
            if (bus.we[k] && !is_zero(wa))
                regs_d[wa] = bus.wdata[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ---------------- read ports with write-first bypass ----------------
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_hit;   // read served from a write port

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_hit  = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra = bus.raddr[j*ADDR_W +: ADDR_W];
            if (rst_ni && bus.re[j] && !is_zero(ra)) begin
                rd_data[j] = regs_q[ra];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.we[k] && bus.waddr[k*ADDR_W +: ADDR_W] == ra) begin
                        rd_data[j] = bus.wdata[k*DATA_W +: DATA_W];
                        rd_hit[j]  = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rdata = rd_data;

`ifdef REGFILE_SCOREBOARD_EN
    // ---------------- busy scoreboard ----------------
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [NUM_RD-1:0] rbusy;

    // Clears first, then the set: a new producer supersedes a completing one.
    // busy[0] is never set under ZERO_REG, so it stays 0 from reset.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k]) busy_d[bus.waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (bus.iss_valid && !is_zero(bus.iss_addr))
            busy_d[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    // A register written this cycle is reported free, matching bypassed data.
    always_comb begin
        rbusy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rbusy[j] = rst_ni & bus.re[j]
                     & busy_q[bus.raddr[j*ADDR_W +: ADDR_W]] & ~rd_hit[j];
        end
    end

    assign bus.rbusy = rbusy;
`else
    logic unused_sb;
    assign unused_sb = ^{bus.iss_valid, bus.iss_addr, rd_hit};
    assign bus.rbusy = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp (default parameters). Expected values are
// queued when stimulus is applied and popped/compared before the next edge.
// Scoreboard expectations follow REGFILE_SCOREBOARD_EN.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
`ifdef REGFILE_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        string       tag;
        int          port;
        bit          is_busy;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic exp_d(input string t, input int p, input logic [31:0] v);
        chk_t c;
        c.tag = t; c.port = p; c.is_busy = 1'b0; c.exp = v;
        q.push_back(c);
    endtask

    task automatic exp_b(input string t, input int p, input logic v);
        chk_t c;
        c.tag = t; c.port = p; c.is_busy = 1'b1; c.exp = {31'b0, v};
        q.push_back(c);
    endtask

    task automatic check_all();
        chk_t c;
        logic [31:0] obs;
        while (q.size() > 0) begin
            c   = q.pop_front();
            obs = c.is_busy ? {31'b0, bus.rbusy[c.port]} : bus.rdata[c.port*DATA_W +: DATA_W];
            n_cmp++;
            assert (obs === c.exp) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", c.tag, obs, c.exp);
            end
        end
    endtask

    task automatic set_wr(input int k, input logic en, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        bus.we[k]                    = en;
        bus.waddr[k*ADDR_W +: ADDR_W] = a;
        bus.wdata[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int j, input logic en, input logic [ADDR_W-1:0] a);
        bus.re[j]                    = en;
        bus.raddr[j*ADDR_W +: ADDR_W] = a;
    endtask

    // Advance through the next rising edge; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_ni        = 1'b0;
        bus.we        = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.re        = '0;
        bus.raddr     = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;

        // ---- reset ----
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd5);
        @(negedge clk); @(negedge clk);
        exp_d("rst_low_rd0", 0, 32'h0); exp_d("rst_low_rd1", 1, 32'h0);
        exp_b("rst_low_bz0", 0, 1'b0);  exp_b("rst_low_bz1", 1, 1'b0);
        #1 check_all();
        rst_ni = 1'b1;
        exp_d("rst_rd0", 0, 32'h0); exp_d("rst_rd1", 1, 32'h0);
        #1 check_all();

        // ---- write x5, then reset mid-operation with a write to x8 pending ----
        set_wr(0, 1'b1, 5'd5, 32'h0000_1234);
        step();
        bus.we = '0;
        set_rd(0, 1'b1, 5'd5);
        exp_d("wr_x5", 0, 32'h0000_1234);
        #1 check_all();
        set_wr(0, 1'b1, 5'd8, 32'h0000_BEEF);
        #1 rst_ni = 1'b0;
        exp_d("rst_force0", 0, 32'h0); exp_d("rst_force1", 1, 32'h0);
        #1 check_all();
        step();
        rst_ni = 1'b1;
        bus.we = '0;
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd8);
        exp_d("x5_cleared", 0, 32'h0); exp_d("x8_dropped", 1, 32'h0);
        #1 check_all();

        // ---- write then read ----
        set_wr(0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        step();
        bus.we = '0;
        set_rd(0, 1'b1, 5'd7);
        exp_d("rd_x7", 0, 32'hDEAD_BEEF);
        #1 check_all();

        // ---- same-cycle bypass ----
        set_wr(0, 1'b1, 5'd9, 32'hA5A5_A5A5);
        set_rd(1, 1'b1, 5'd9);
        exp_d("byp_x9", 1, 32'hA5A5_A5A5); exp_d("byp_x7", 0, 32'hDEAD_BEEF);
        #1 check_all();
        step();
        bus.we = '0;
        set_rd(0, 1'b1, 5'd9);
        exp_d("x9_arr", 0, 32'hA5A5_A5A5);
        #1 check_all();

        // ---- write priority ----
        set_wr(0, 1'b1, 5'd4, 32'h0000_0011);
        set_wr(1, 1'b1, 5'd4, 32'h0000_0022);
        set_rd(0, 1'b1, 5'd4);
        exp_d("prio_byp", 0, 32'h0000_0022);
        #1 check_all();
        step();
        bus.we = '0;
        exp_d("prio_arr", 0, 32'h0000_0022);
        #1 check_all();

        // ---- two ports, distinct addresses ----
        set_wr(0, 1'b1, 5'd10, 32'h1010_1010);
        set_wr(1, 1'b1, 5'd11, 32'h1111_1111);
        set_rd(0, 1'b1, 5'd11);
        set_rd(1, 1'b1, 5'd10);
        exp_d("dual_byp0", 0, 32'h1111_1111); exp_d("dual_byp1", 1, 32'h1010_1010);
        #1 check_all();
        step();
        bus.we = '0;
        exp_d("dual_arr0", 0, 32'h1111_1111); exp_d("dual_arr1", 1, 32'h1010_1010);
        #1 check_all();

        // ---- zero register ----
        set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_rd(0, 1'b1, 5'd0);
        exp_d("x0_byp", 0, 32'h0);
        #1 check_all();
        step();
        bus.we        = '0;
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd0;
        exp_d("x0_arr", 0, 32'h0);
        #1 check_all();
        step();
        bus.iss_valid = 1'b0;
        exp_b("x0_busy", 0, 1'b0);
        #1 check_all();

        // ---- read enable off ----
        set_rd(0, 1'b0, 5'd7);
        exp_d("re_off_data", 0, 32'h0);
        #1 check_all();

        // ---- scoreboard ----
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd12;
        set_rd(0, 1'b1, 5'd12);
        set_rd(1, 1'b1, 5'd13);
        exp_b("iss_same_cyc", 0, 1'b0);
        #1 check_all();
        step();
        bus.iss_valid = 1'b0;
        exp_b("busy_set", 0, SB); exp_b("busy_other", 1, 1'b0);
        exp_d("busy_data", 0, 32'h0);
        #1 check_all();
        set_rd(1, 1'b0, 5'd12);
        exp_b("busy_re_off", 1, 1'b0);
        #1 check_all();
        set_wr(1, 1'b1, 5'd12, 32'h0000_0055);
        exp_b("clr_byp", 0, 1'b0); exp_d("clr_byp_data", 0, 32'h0000_0055);
        #1 check_all();
        step();
        bus.we = '0;
        exp_b("clr_after", 0, 1'b0); exp_d("clr_after_data", 0, 32'h0000_0055);
        #1 check_all();

        // set and clear on the same edge: set wins
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd12;
        set_wr(0, 1'b1, 5'd12, 32'h0000_0066);
        exp_b("setclr_byp", 0, 1'b0); exp_d("setclr_data", 0, 32'h0000_0066);
        #1 check_all();
        step();
        bus.iss_valid = 1'b0;
        bus.we        = '0;
        exp_b("set_wins", 0, SB); exp_d("set_wins_data", 0, 32'h0000_0066);
        #1 check_all();

        // clear through port 0
        set_wr(0, 1'b1, 5'd12, 32'h0000_0077);
        step();
        bus.we = '0;
        exp_b("clr_p0", 0, 1'b0); exp_d("clr_p0_data", 0, 32'h0000_0077);
        #1 check_all();

        // reset clears busy bits and the array
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd20;
        step();
        bus.iss_valid = 1'b0;
        set_rd(0, 1'b1, 5'd20);
        set_rd(1, 1'b1, 5'd7);
        exp_b("busy20", 0, SB);
        #1 check_all();
        rst_ni = 1'b0;
        exp_b("rst_bz_force", 0, 1'b0);
        #1 check_all();
        step();
        rst_ni = 1'b1;
        exp_b("rst_busy20", 0, 1'b0); exp_d("rst_x7", 1, 32'h0);
        #1 check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
